load_store_unit: RTL and testbench

Multi-cycle load/store unit that sits directly downstream of the MIPS ALU. It takes the ALU result as an effective address, performs byte, halfword or word accesses over a request/acknowledge memory bus, and returns sign- or zero-extended load data for register writeback. The unit stalls the datapath through `busy` while a bus transaction is outstanding.

---
 rtl/load_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Multi-cycle load/store unit placed after the ALU. It takes the ALU result as
//   an effective address and performs byte, halfword or word accesses over a
//   request/acknowledge bus. Load data is returned sign- or zero-extended.
//   `busy` stalls the datapath while an access is in flight.
//
// Ports
//   clk, reset        : clock and asynchronous active-high reset
//   start             : request an access (sampled only when idle)
//   mem_write         : 1 = store, 0 = load
//   size              : 00 byte, 01 half, 10 word, 11 reserved
//   load_unsigned     : 1 = zero-extend, 0 = sign-extend (ignored for words)
//   addr, wdata       : effective address and store data
//   busy, done        : in-flight indicator and one-cycle completion pulse
//   rdata             : extended load result, held until the next load completes
//   fault_align       : misaligned address or reserved size (valid with done)
//   fault_timeout     : no bus_ack within TIMEOUT_CYCLES (valid with done)
//   bus_*             : memory bus request side and read data return
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault_align,
  output logic        fault_timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value seen in the final allowed REQ cycle (counter starts at 0).
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          fa_q, fa_d;
  logic          ft_q, ft_d;

  logic          misaligned;
  logic [15:0]   lane;
  logic [31:0]   load_ext;
  logic          in_req;

  always_comb begin
    unique case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = |addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Shift the addressed lane down to bit 0; only the low half is ever needed.
  always_comb begin
    lane = 16'(bus_rdata >> {addr_q[1:0], 3'b000});
    unique case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_ext = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fa_d    = fa_q;
    ft_d    = ft_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          we_d    = mem_write;
          size_d  = size;
          uns_d   = load_unsigned;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = '0;
          fa_d    = misaligned;
          ft_d    = 1'b0;
          state_d = misaligned ? S_FAULT : S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        // Ack takes priority over the timeout in the final allowed cycle.
        if (bus_ack) begin
          if (!we_q) rdata_d = load_ext;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          ft_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      fa_q    <= 1'b0;
      ft_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fa_q    <= fa_d;
      ft_q    <= ft_d;
    end
  end

  assign in_req        = (state_q == S_REQ);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE) || (state_q == S_FAULT);
  assign rdata         = rdata_q;
  assign fault_align   = fa_q;
  assign fault_timeout = ft_q;
  assign bus_req       = in_req;
  assign bus_we        = in_req & we_q;
  assign bus_addr      = in_req ? {addr_q[31:2], 2'b00} : '0;

  // Bus drive is gated to REQ so every bus output is 0 outside a transaction.
  always_comb begin
    bus_be    = '0;
    bus_wdata = '0;
    if (in_req) begin
      unique case (size_q)
        2'b00: begin
          bus_be    = 4'b0001 << addr_q[1:0];
          bus_wdata = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          bus_be    = addr_q[1] ? 4'b1100 : 4'b0011;
          bus_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          bus_be    = 4'b1111;
          bus_wdata = wdata_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with TIMEOUT_CYCLES = 4. Each access pushes its
// expected completion onto a scoreboard queue; the entry is popped and
// compared when the unit raises done.
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mem_write;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        fault_align;
  logic        fault_timeout;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_write(mem_write),
    .size(size), .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .fault_align(fault_align),
    .fault_timeout(fault_timeout), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        fa;
    logic        ft;
    int          lat;
    int          reqs;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_rd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge with the unit idle; returns one cycle
  // after done, again just after a rising edge.
  task automatic run_access(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int ack_at, input logic [31:0] rd);
    exp_t        e;
    exp_t        got_e;
    logic        mis;
    logic [31:0] sh;
    logic [31:0] val;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    int          cyc;
    int          reqs;

    mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    sh  = rd >> (8 * a[1:0]);
    case (sz)
      2'b00: begin
        val = sh & 32'h0000_00FF;
        if (!uns && sh[7]) val = val | 32'hFFFF_FF00;
        ebe = 4'b0001 << a[1:0];
        ewd = {4{wd[7:0]}};
      end
      2'b01: begin
        val = sh & 32'h0000_FFFF;
        if (!uns && sh[15]) val = val | 32'hFFFF_0000;
        ebe = a[1] ? 4'b1100 : 4'b0011;
        ewd = {2{wd[15:0]}};
      end
      default: begin
        val = rd;
        ebe = 4'b1111;
        ewd = wd;
      end
    endcase

    e.fa = mis;
    if (mis) begin
      e.ft = 1'b0; e.lat = 1; e.reqs = 0;
    end else if (ack_at >= 1 && ack_at <= TMO) begin
      e.ft = 1'b0; e.lat = ack_at + 1; e.reqs = ack_at;
      if (!we) exp_rd = val;
    end else begin
      e.ft = 1'b1; e.lat = TMO + 1; e.reqs = TMO;
    end
    e.rdata = exp_rd;
    sb.push_back(e);

    start = 1'b1; mem_write = we; size = sz; load_unsigned = uns; addr = a; wdata = wd;
    bus_rdata = rd;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; reqs = 0;
    while (!done && cyc < 40) begin
      if (bus_req) begin
        reqs++;
        if (reqs == 1) begin
          check("bus_addr", bus_addr, {a[31:2], 2'b00});
          check("bus_be", {28'h0, bus_be}, {28'h0, ebe});
          check("bus_we", {31'h0, bus_we}, {31'h0, we});
          if (we) check("bus_wdata", bus_wdata, ewd);
        end
        bus_ack = (reqs == ack_at);
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
      cyc++;
    end

    got_e = sb.pop_front();
    if (done) begin
      check("rdata", rdata, got_e.rdata);
      check("fault_align", {31'h0, fault_align}, {31'h0, got_e.fa});
      check("fault_timeout", {31'h0, fault_timeout}, {31'h0, got_e.ft});
      check("latency", 32'(cyc), 32'(got_e.lat));
      check("req_cycles", 32'(reqs), 32'(got_e.reqs));
    end else begin
      check("done_wait", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    check("done_pulse", {31'h0, done}, 32'd0);
    check("busy_after", {31'h0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; mem_write = 1'b0; size = 2'b00; load_unsigned = 1'b0;
    addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    #3;
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_bus_req", {31'h0, bus_req}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Word load, zero-wait ack.
    run_access(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 1, 32'hDEAD_BEEF);
    // Byte loads from lane 3, signed then unsigned (back-to-back).
    run_access(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 1, 32'h80FF_7F01);
    run_access(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 1, 32'h80FF_7F01);
    // Half loads, upper signed and lower unsigned.
    run_access(1'b0, 2'b01, 1'b0, 32'h0000_1002, 32'h0, 2, 32'h80FF_7F01);
    run_access(1'b0, 2'b01, 1'b1, 32'h0000_1000, 32'h0, 1, 32'h80FF_7F01);
    // Stores leave rdata untouched.
    run_access(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 2, 32'h5555_5555);
    run_access(1'b1, 2'b00, 1'b0, 32'h0000_1001, 32'h0000_00A5, 1, 32'h0);
    // Misaligned and reserved size.
    run_access(1'b0, 2'b10, 1'b0, 32'h0000_2001, 32'h0, 1, 32'h1111_1111);
    run_access(1'b0, 2'b01, 1'b0, 32'h0000_2003, 32'h0, 1, 32'h1111_1111);
    run_access(1'b0, 2'b11, 1'b0, 32'h0000_2000, 32'h0, 1, 32'h1111_1111);
    // Ack in the last allowed cycle wins; then no ack at all.
    run_access(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0, TMO, 32'h1234_5678);
    run_access(1'b0, 2'b10, 1'b0, 32'h0000_3004, 32'h0, 0, 32'h9999_9999);

    // Late ack while idle must be ignored.
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    check("late_ack_done", {31'h0, done}, 32'd0);
    check("late_ack_busy", {31'h0, busy}, 32'd0);
    check("late_ack_rdata", rdata, exp_rd);

    // Start while busy is ignored; reset mid-REQ clears everything at once.
    mem_write = 1'b0; size = 2'b10; load_unsigned = 1'b0; addr = 32'h0000_3000; start = 1'b1;
    @(posedge clk); #1;
    addr = 32'h0000_4000;
    check("req_addr", bus_addr, 32'h0000_3000);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_start_ignored", bus_addr, 32'h0000_3000);
    check("busy_start_req", {31'h0, bus_req}, 32'd1);
    reset = 1'b1;
    #1;
    exp_rd = '0;
    check("rst_req", {31'h0, bus_req}, 32'd0);
    check("rst_busy2", {31'h0, busy}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_rdata2", rdata, 32'd0);
    check("rst_faults", {30'h0, fault_align, fault_timeout}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_access(1'b0, 2'b00, 1'b1, 32'h0000_5002, 32'h0, 3, 32'h00C3_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
